// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: FSM state encoding and the
// byte/word geometry of the load stream.
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

endpackage : loader_pkg

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Groups the byte-stream handshake and the instruction-memory write port
// that the loader sits between.
//   rx_data/rx_valid/rx_ready : byte stream, accepted when valid && ready
//   imem_wr_en/addr/data      : one-cycle word write into instruction memory
// Modports:
//   slave  - the loader (consumes bytes, produces memory writes)
//   master - the byte source / memory side
// ---------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [31:0]       imem_wr_data;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );
endinterface : program_loader_if

// File: rtl/program_loader_byte_assembler.sv
// ---------------------------------------------------------------------------
// byte_assembler
// Collects bytes MSB first into a big-endian 32-bit word. word_valid is
// combinational and high together with the 4th accepted byte, so the
// caller sees the complete word on the same edge that consumes that byte.
// Ports:
//   CLOCK_50, RESET  clock, async active-low reset
//   clear            synchronous clear of byte count and partial word
//   byte_valid       a byte is accepted this cycle
//   byte_data        accepted byte
//   word_valid       4th byte of a word is being accepted
//   word             assembled word (valid with word_valid)
// ---------------------------------------------------------------------------
module byte_assembler
    import loader_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    assign word_valid = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {shift_q, byte_data};

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shift_q  <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= {shift_q[15:0], byte_data};
        end
    end
endmodule : byte_assembler

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Responder side of the start_program_loading -> program_loaded handshake.
// Receives a stream: 4-byte length N, N big-endian data words, and (with
// LOADER_CHECKSUM_EN defined) a checksum word equal to the 32-bit
// wraparound sum of the data words. Each data word is written to
// instruction memory with a registered one-cycle strobe.
// Optional feature macro: LOADER_CHECKSUM_EN.
// Ports:
//   CLOCK_50               system clock
//   RESET                  async active-low reset
//   start_program_loading  level request; the load runs while high
//   bus (slave)            byte stream in, instruction-memory write out
//   program_loaded         load complete (level, held while start high)
//   load_error             bad length / checksum (level, held while start high)
//   words_loaded           data words written during this load
// ---------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start_program_loading,
    program_loader_if.slave   bus,
    output logic              program_loaded,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CW = ADDR_W + 1;

    loader_state_t state, state_next;
    logic          accept;
    logic          asm_clear;
    logic          word_valid;
    logic [31:0]   word;
    logic [CW-1:0] last_idx;     // N-1, index of the final data word
    logic          hdr_bad;
    logic          last_word;
    logic          start_load;   // IDLE -> HDR: fresh load begins
    logic          do_write;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   csum_acc;
`endif

    // Stream is only open in the receiving states and while start is held,
    // so a beat coincident with start falling is never accepted.
    assign bus.rx_ready = start_program_loading &&
                          (state == ST_HDR || state == ST_DATA || state == ST_CSUM);
    assign accept       = bus.rx_valid && bus.rx_ready;

    byte_assembler u_asm (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .clear      (asm_clear),
        .byte_valid (accept),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign hdr_bad    = (word == 32'd0) || (word > 32'(MAX_WORDS));
    assign last_word  = (words_loaded == last_idx);
    assign start_load = (state == ST_IDLE) && start_program_loading;
    assign do_write   = (state == ST_DATA) && word_valid;

    // Partial words never survive a state change.
    assign asm_clear  = (state_next != state);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; an unassigned path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start_program_loading) state_next = ST_HDR;
            end
            ST_HDR: begin
                if (!start_program_loading) state_next = ST_IDLE;
                else if (word_valid)        state_next = hdr_bad ? ST_ERROR : ST_DATA;
            end
            ST_DATA: begin
                if (!start_program_loading) state_next = ST_IDLE;
                else if (word_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (!start_program_loading) state_next = ST_IDLE;
                else if (word_valid)        state_next = (word == csum_acc) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (!start_program_loading) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word index doubles as words_loaded; cleared when a new load starts.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            words_loaded <= '0;
            last_idx     <= '0;
        end else begin
            if (start_load)     words_loaded <= '0;
            else if (do_write)  words_loaded <= words_loaded + CW'(1);
            if (state == ST_HDR && word_valid && !hdr_bad)
                last_idx <= CW'(word - 32'd1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            csum_acc <= '0;
        end else if (start_load) begin
            csum_acc <= '0;
        end else if (do_write) begin
            csum_acc <= csum_acc + word;
        end
    end
`endif

    // Registered outputs: the write strobe follows the completing byte by
    // one cycle, and status levels drop on the same edge the FSM leaves
    // DONE/ERROR so the two flags can never overlap.
    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            bus.imem_wr_en   <= 1'b0;
            bus.imem_wr_addr <= '0;
            bus.imem_wr_data <= '0;
            program_loaded   <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            bus.imem_wr_en <= do_write;
            if (do_write) begin
                bus.imem_wr_addr <= words_loaded[ADDR_W-1:0];
                bus.imem_wr_data <= word;
            end
            program_loaded <= (state == ST_DONE)  && start_program_loading;
            load_error     <= (state == ST_ERROR) && start_program_loading;
        end
    end
endmodule : program_loader

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Directed stimulus for program_loader. Expected memory writes are queued
// when a word is sent; a monitor pops and compares on every imem_wr_en.
// ---------------------------------------------------------------------------
module tb_program_loader;
    import loader_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic            CLOCK_50 = 1'b0;
    logic            RESET    = 1'b0;
    logic            start    = 1'b0;
    logic            program_loaded;
    logic            load_error;
    logic [ADDR_W:0] words_loaded;

    int  n_cmp  = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .CLOCK_50              (CLOCK_50),
        .RESET                 (RESET),
        .start_program_loading (start),
        .bus                   (bus),
        .program_loaded        (program_loaded),
        .load_error            (load_error),
        .words_loaded          (words_loaded)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the queue head.
    always @(negedge CLOCK_50) begin
        if (bus.imem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.imem_wr_addr, bus.imem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.imem_wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(bus.imem_wr_data), 64'(mon_e.data));
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; rx_ready is sampled on
    // the falling edge, where it is stable for the coming rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge CLOCK_50);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge CLOCK_50);
            if (bus.rx_ready === 1'b1) begin
                @(posedge CLOCK_50);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL byte_accept_timeout: got rx_ready 0 expected 1");
                break;
            end
            @(posedge CLOCK_50);
            #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] b;
            b = w[i*8 +: 8];
            send_byte(b, gaps ? int'($urandom_range(0, 20)) : 0);
        end
    endtask

    // Sends data words and queues the expected write for each.
    task automatic send_data(input logic [31:0] w, input int addr, input bit gaps);
        exp_q.push_back('{addr: ADDR_W'(addr), data: w});
        send_word(w, gaps);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic end_load();
        start = 1'b0;
        cycles(3);
    endtask

    task automatic run_three_word(input bit gaps, input string tag);
        start = 1'b1;
        send_word(32'h0000_0003, gaps);
        send_data(32'h1122_3344, 0, gaps);
        send_data(32'h5566_7788, 1, gaps);
        send_data(32'h99AA_BBCC, 2, gaps);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h1122_3344 + 32'h5566_7788 + 32'h99AA_BBCC, gaps);
`endif
        @(negedge CLOCK_50);
        check({tag, "_loaded_not_yet"}, 64'(program_loaded), 64'd0);
        @(negedge CLOCK_50);
        check({tag, "_loaded"}, 64'(program_loaded), 64'd1);
        check({tag, "_words"}, 64'(words_loaded), 64'd3);
        check({tag, "_no_error"}, 64'(load_error), 64'd0);
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        #1;
        start = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check({tag, "_loaded_cleared"}, 64'(program_loaded), 64'd0);
        cycles(2);
    endtask

    task automatic bad_header(input logic [31:0] n, input string tag);
        start = 1'b1;
        send_word(n, 1'b0);
        cycles(3);
        check({tag, "_error"}, 64'(load_error), 64'd1);
        check({tag, "_not_loaded"}, 64'(program_loaded), 64'd0);
        check({tag, "_ready_low"}, 64'(bus.rx_ready), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
        start = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check({tag, "_error_cleared"}, 64'(load_error), 64'd0);
        cycles(2);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset state
        cycles(2);
        check("rst_wr_en", 64'(bus.imem_wr_en), 64'd0);
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        check("rst_loaded", 64'(program_loaded), 64'd0);
        check("rst_error", 64'(load_error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        RESET = 1'b1;
        cycles(2);
        check("idle_rx_ready", 64'(bus.rx_ready), 64'd0);

        // Basic three-word load, then the same stream with random gaps
        run_three_word(1'b0, "t1");
        run_three_word(1'b1, "t3");

        // Length out of range
        bad_header(32'h0000_0000, "t2_zero");
        bad_header(32'(MAX_WORDS + 1), "t2_over");

        // Start dropped mid-load after 6 data bytes of N=4
        start = 1'b1;
        send_word(32'h0000_0004, 1'b0);
        send_data(32'hAABB_CCDD, 0, 1'b0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        start = 1'b0;
        cycles(3);
        check("t4_abort_loaded", 64'(program_loaded), 64'd0);
        check("t4_abort_error", 64'(load_error), 64'd0);
        check("t4_abort_ready", 64'(bus.rx_ready), 64'd0);
        check("t4_abort_words", 64'(words_loaded), 64'd1);
        check("t4_abort_queue", 64'(exp_q.size()), 64'd0);
        start = 1'b1;
        send_word(32'h0000_0002, 1'b0);
        check("t4_restart_words", 64'(words_loaded), 64'd0);
        send_data(32'hDEAD_BEEF, 0, 1'b0);
        send_data(32'hCAFE_F00D, 1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BEEF + 32'hCAFE_F00D, 1'b0);
`endif
        cycles(2);
        check("t4_loaded", 64'(program_loaded), 64'd1);
        check("t4_words", 64'(words_loaded), 64'd2);
        end_load();

        // Async reset while the 4th byte of the second word is presented
        start = 1'b1;
        send_word(32'h0000_0002, 1'b0);
        send_data(32'h0102_0304, 0, 1'b0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        bus.rx_data  = 8'h44;
        bus.rx_valid = 1'b1;
        @(negedge CLOCK_50);
        check("t5_words_before", 64'(words_loaded), 64'd1);
        #5;
        RESET = 1'b0;
        @(posedge CLOCK_50);
        #1;
        bus.rx_valid = 1'b0;
        start = 1'b0;
        @(negedge CLOCK_50);
        check("t5_wr_en", 64'(bus.imem_wr_en), 64'd0);
        check("t5_words", 64'(words_loaded), 64'd0);
        check("t5_loaded", 64'(program_loaded), 64'd0);
        check("t5_error", 64'(load_error), 64'd0);
        check("t5_ready", 64'(bus.rx_ready), 64'd0);
        RESET = 1'b1;
        cycles(2);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match (1 + FFFFFFFF wraps to 0) and mismatch
        start = 1'b1;
        send_word(32'h0000_0002, 1'b0);
        send_data(32'h0000_0001, 0, 1'b0);
        send_data(32'hFFFF_FFFF, 1, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        cycles(2);
        check("t6_match_loaded", 64'(program_loaded), 64'd1);
        check("t6_match_error", 64'(load_error), 64'd0);
        end_load();
        start = 1'b1;
        send_word(32'h0000_0002, 1'b0);
        send_data(32'h0000_0001, 0, 1'b0);
        send_data(32'hFFFF_FFFF, 1, 1'b0);
        send_word(32'h0000_0001, 1'b0);
        cycles(2);
        check("t6_bad_error", 64'(load_error), 64'd1);
        check("t6_bad_loaded", 64'(program_loaded), 64'd0);
        end_load();
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule : tb_program_loader
